voice_alloc: RTL

//  Polyphonic voice scheduler between the MIDI parser and the tone generators.

---
 rtl/voice_alloc_pkg.sv | 14 +
 rtl/voice_find.sv | 46 ++++
 rtl/voice_alloc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared widths, defaults and FSM state encoding for the voice allocator.
package voice_alloc_pkg;

    localparam int unsigned MIDI_PAYLOAD_BITS = 7;
    localparam int unsigned NUM_VOICES_DEF    = 4;
    localparam int unsigned VOICE_AGE_BW      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/voice_find.sv
// Combinational voice lookup: note match, lowest free voice, LRU victim.
module voice_find #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_BW     = 2,
    parameter int unsigned NOTE_BW    = 7
) (
    input  logic [NUM_VOICES-1:0]         gate_i,
    input  logic [NUM_VOICES*NOTE_BW-1:0] notes_i,
    input  logic [NUM_VOICES*AGE_BW-1:0]  ages_i,
    input  logic [NOTE_BW-1:0]            key_i,
    output logic [NUM_VOICES-1:0]         match_vec_o,
    output logic                          match_any_o,
    output logic [AGE_BW-1:0]             match_idx_o,
    output logic                          free_any_o,
    output logic [AGE_BW-1:0]             free_idx_o,
    output logic [AGE_BW-1:0]             victim_idx_o
);

    always_comb begin
        match_vec_o  = '0;
        match_any_o  = 1'b0;
        match_idx_o  = '0;
        free_any_o   = 1'b0;
        free_idx_o   = '0;
        victim_idx_o = '0;
        // Scan from the top down so the lowest index is the last writer.
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            int unsigned v;
            logic        hit;
            v   = NUM_VOICES - 1 - i;
            hit = gate_i[v] && (notes_i[v*NOTE_BW +: NOTE_BW] == key_i);
            match_vec_o[v] = hit;
            if (hit) begin
                match_any_o = 1'b1;
                match_idx_o = AGE_BW'(v);
            end
            if (!gate_i[v]) begin
                free_any_o = 1'b1;
                free_idx_o = AGE_BW'(v);
            end
            if (ages_i[v*AGE_BW +: AGE_BW] == AGE_BW'(NUM_VOICES - 1))
                victim_idx_o = AGE_BW'(v);
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice scheduler: retrigger, else lowest free voice, else steal LRU.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned AGE_BW     = VOICE_AGE_BW
) (
    input  logic                                  clk_i,
    input  logic                                  nrst_i,
    input  logic [2:0]                            chSel_i,
    input  logic [2:0]                            ch_i,
    input  logic [MIDI_PAYLOAD_BITS-1:0]          note_i,
    input  logic                                  noteOnStrb_i,
    input  logic                                  noteOffStrb_i,
    input  logic                                  panic_i,
    output logic [NUM_VOICES*MIDI_PAYLOAD_BITS-1:0] voiceNote_o,
    output logic [NUM_VOICES-1:0]                 voiceGate_o,
    output logic [NUM_VOICES-1:0]                 voiceTrigStrb_o,
    output logic                                  stealStrb_o,
    output logic                                  busy_o,
    output logic                                  dropStrb_o
);

    localparam int unsigned P = MIDI_PAYLOAD_BITS;

    state_t                      state_q, state_d;
    logic                        is_on_q, is_on_d;
    logic [P-1:0]                key_q, key_d;
    logic [NUM_VOICES-1:0]       match_vec_q, match_vec_d;
    logic                        match_any_q, match_any_d;
    logic [AGE_BW-1:0]           match_idx_q, match_idx_d;
    logic                        free_any_q, free_any_d;
    logic [AGE_BW-1:0]           free_idx_q, free_idx_d;
    logic [AGE_BW-1:0]           victim_idx_q, victim_idx_d;
    logic [NUM_VOICES-1:0]       gate_q, gate_d;
    logic [NUM_VOICES*P-1:0]     notes_q, notes_d;
    logic [NUM_VOICES*AGE_BW-1:0] ages_q, ages_d;
    logic [NUM_VOICES-1:0]       trig_q, trig_d;
    logic                        steal_q, steal_d;
    logic                        drop_q, drop_d;

    logic [NUM_VOICES-1:0]       f_match_vec;
    logic                        f_match_any, f_free_any;
    logic [AGE_BW-1:0]           f_match_idx, f_free_idx, f_victim_idx;
    logic                        accept;
    logic [AGE_BW-1:0]           tgt, tgt_age, age_u;

    voice_find #(
        .NUM_VOICES(NUM_VOICES),
        .AGE_BW    (AGE_BW),
        .NOTE_BW   (P)
    ) u_find (
        .gate_i      (gate_q),
        .notes_i     (notes_q),
        .ages_i      (ages_q),
        .key_i       (key_q),
        .match_vec_o (f_match_vec),
        .match_any_o (f_match_any),
        .match_idx_o (f_match_idx),
        .free_any_o  (f_free_any),
        .free_idx_o  (f_free_idx),
        .victim_idx_o(f_victim_idx)
    );

    always_comb begin
        state_d      = state_q;
        is_on_d      = is_on_q;
        key_d        = key_q;
        match_vec_d  = match_vec_q;
        match_any_d  = match_any_q;
        match_idx_d  = match_idx_q;
        free_any_d   = free_any_q;
        free_idx_d   = free_idx_q;
        victim_idx_d = victim_idx_q;
        gate_d       = gate_q;
        notes_d      = notes_q;
        ages_d       = ages_q;
        trig_d       = '0;
        steal_d      = 1'b0;
        drop_d       = 1'b0;
        tgt          = '0;
        tgt_age      = '0;
        age_u        = '0;
        accept       = (ch_i == chSel_i) && (noteOnStrb_i || noteOffStrb_i);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_on_d = noteOnStrb_i;
                    key_d   = note_i;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                match_vec_d  = f_match_vec;
                match_any_d  = f_match_any;
                match_idx_d  = f_match_idx;
                free_any_d   = f_free_any;
                free_idx_d   = f_free_idx;
                victim_idx_d = f_victim_idx;
                state_d      = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (is_on_q) begin
                    tgt     = match_any_q ? match_idx_q :
                              free_any_q  ? free_idx_q  : victim_idx_q;
                    steal_d = !match_any_q && !free_any_q;
                    for (int unsigned u = 0; u < NUM_VOICES; u++)
                        if (AGE_BW'(u) == tgt) tgt_age = ages_q[u*AGE_BW +: AGE_BW];
                    // Ranks younger than the target age by one; target becomes newest.
                    for (int unsigned u = 0; u < NUM_VOICES; u++) begin
                        age_u = ages_q[u*AGE_BW +: AGE_BW];
                        if (AGE_BW'(u) == tgt) begin
                            ages_d[u*AGE_BW +: AGE_BW] = '0;
                            trig_d[u] = 1'b1;
                            if (!match_any_q) begin
                                notes_d[u*P +: P] = key_q;
                                gate_d[u]         = 1'b1;
                            end
                        end else if (age_u < tgt_age) begin
                            ages_d[u*AGE_BW +: AGE_BW] = age_u + AGE_BW'(1);
                        end
                    end
                end else begin
                    gate_d = gate_q & ~match_vec_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && accept && !drop_q)
            drop_d = 1'b1;

        if (panic_i) begin
            state_d = ST_IDLE;
            gate_d  = '0;
            trig_d  = '0;
            steal_d = 1'b0;
            drop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q      <= ST_IDLE;
            is_on_q      <= 1'b0;
            key_q        <= '0;
            match_vec_q  <= '0;
            match_any_q  <= 1'b0;
            match_idx_q  <= '0;
            free_any_q   <= 1'b0;
            free_idx_q   <= '0;
            victim_idx_q <= '0;
            gate_q       <= '0;
            notes_q      <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++)
                ages_q[v*AGE_BW +: AGE_BW] <= AGE_BW'(v);
            trig_q       <= '0;
            steal_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_on_q      <= is_on_d;
            key_q        <= key_d;
            match_vec_q  <= match_vec_d;
            match_any_q  <= match_any_d;
            match_idx_q  <= match_idx_d;
            free_any_q   <= free_any_d;
            free_idx_q   <= free_idx_d;
            victim_idx_q <= victim_idx_d;
            gate_q       <= gate_d;
            notes_q      <= notes_d;
            ages_q       <= ages_d;
            trig_q       <= trig_d;
            steal_q      <= steal_d;
            drop_q       <= drop_d;
        end
    end

    assign voiceNote_o     = notes_q;
    assign voiceGate_o     = gate_q;
    assign voiceTrigStrb_o = trig_q;
    assign stealStrb_o     = steal_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign dropStrb_o      = drop_q;

endmodule
